pipe_control_unit: RTL and testbench
====================================

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 Parameter FUNC_W, default 5, width of the func field; must be >= 5.
REQ-002 Parameter REG_W, default 4, width of register-address fields.
REQ-003 Parameter DIV_CYCLES, default 4, total EX occupancy of a divide; must be >= 1.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  decode-stage instruction present.
REQ-007 instruction_type  in  2  00 memory, 01 data, 10 control, 11 illegal.
REQ-008 func  in  FUNC_W  function field; only bits [4:0] are decoded.
REQ-009 rs1, rs2  in  REG_W each  source register addresses.
REQ-010 ex_mem_read, ex_rd  in  1, REG_W  load in EX and its destination register.
REQ-011 branch_taken  in  1  EX resolved a taken branch; flush decode.
REQ-012 in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
REQ-013 out_valid  out  1  registered control bundle is a real instruction.
REQ-014 BranchB, BranchI, BranchNI, MemToReg, MemRead, MemWrite, ALUSrc, RegWrite, RegSrc2, RegSrc1  out  1 each  registered control signals.
REQ-015 ALUOp, ImmSrc  out  3, 2  registered ALU operation and immediate format.
REQ-016 illegal  out  1  registered flag, accepted instruction was undecodable.
REQ-017 busy  out  1  high while in DIV_BUSY.

Function
REQ-018 All outputs except in_ready and busy are registered; decode-to-output latency is exactly 1 cycle.
REQ-019 Bubble = out_valid 0, all control bits 0, ALUOp 000, ImmSrc 00, illegal 0; no output is ever X.
REQ-020 Data, func[4]=0: ALUSrc 0, RegWrite 1, RegSrc1/2 0, ImmSrc 00; func[4:0] 00000/00001/00010/00011 -> ALUOp 000/001/010/011; any other -> illegal.
REQ-021 Data, func[4]=1: ALUSrc 1, RegWrite 1, ImmSrc 10, RegSrc1 0, RegSrc2 0; 10100..10111 -> ALUOp 000..011; any other -> illegal.
REQ-022 Memory: ALUSrc 1, ALUOp 000, ImmSrc 01; func[4]=1 store (MemWrite 1, RegWrite 0, MemToReg 0); func[4]=0 load (MemRead 1, MemToReg 1, RegWrite 1).
REQ-023 Control: ALUOp 001, ImmSrc 00, RegSrc1/2 1; func[4:3] 00 BranchB, 10 BranchI, 11 BranchNI; 01 -> illegal.
REQ-024 Illegal: bundle is bubble but out_valid 1 and illegal 1.
REQ-025 FSM states RUN, DIV_BUSY; reset enters RUN.
REQ-026 Load-use hazard = ex_mem_read && ex_rd != 0 && (ex_rd == rs1 || (ex_rd == rs2 && rs2 used)); rs2 used only for data func[4]=0, store, BranchI, BranchNI.
REQ-027 RUN: in_ready = !hazard || branch_taken; busy 0.
REQ-028 Priority per cycle: rst > branch_taken > hazard > accept.
REQ-029 branch_taken in RUN: any presented instruction is consumed and dropped; next output is bubble.
REQ-030 hazard without branch_taken: in_ready 0, next output is bubble, instruction held by upstream.
REQ-031 Accepted divide (ALUOp 011, legal): bundle issued next cycle; if DIV_CYCLES > 1, FSM enters DIV_BUSY with counter = DIV_CYCLES-1.
REQ-032 DIV_BUSY: in_ready 0, busy 1, outputs bubble, counter decrements each cycle, return to RUN when counter reaches 1 after that cycle; branch_taken ignored.
REQ-033 in_valid 0 in RUN: next output is bubble.

Reset
REQ-034 rst asserted: outputs forced to bubble immediately, FSM to RUN, counter 0, busy 0; in_ready is 1 as soon as rst deasserts.
REQ-035 Reset mid-DIV_BUSY aborts the divide; no further busy cycles after release.

Verification
REQ-036 add (01, 00000), in_valid 1 -> next cycle out_valid 1, RegWrite 1, ALUOp 000, ALUSrc 0.
REQ-037 ex_mem_read 1, ex_rd 3, load with rs1 3 -> in_ready 0, bubble; ex_mem_read 0 next cycle -> accepted, MemRead 1, MemToReg 1, ImmSrc 01.
REQ-038 divi (01, 10111), DIV_CYCLES 4 -> 1 valid cycle with ALUOp 011, then 3 cycles busy 1, in_ready 0; in_ready 1 on 4th cycle.
REQ-039 branch_taken 1 with BranchI instruction presented -> in_ready 1, next output bubble, BranchI 0.
REQ-040 type 10, func 01000 -> out_valid 1, illegal 1, all controls 0.
REQ-041 rst pulse during second DIV_BUSY cycle -> outputs bubble immediately, busy 0, in_ready 1 after release.

Source files
------------

// File: rtl/pipe_control_unit.sv
// Decode-stage control unit: registered control bundle, load-use stall,
// branch flush and multi-cycle divide occupancy of EX.
module pipe_control_unit #(
  parameter int FUNC_W     = 5,
  parameter int REG_W      = 4,
  parameter int DIV_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        instruction_type,
  input  logic [FUNC_W-1:0] func,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              branch_taken,
  output logic              in_ready,
  output logic              out_valid,
  output logic              BranchB,
  output logic              BranchI,
  output logic              BranchNI,
  output logic              MemToReg,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              ALUSrc,
  output logic              RegWrite,
  output logic              RegSrc2,
  output logic              RegSrc1,
  output logic [2:0]        ALUOp,
  output logic [1:0]        ImmSrc,
  output logic              illegal,
  output logic              busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef struct packed {
    logic       valid;
    logic       bb;
    logic       bi;
    logic       bni;
    logic       m2r;
    logic       mr;
    logic       mw;
    logic       alusrc;
    logic       rw;
    logic       rsrc2;
    logic       rsrc1;
    logic [2:0] aluop;
    logic [1:0] imm;
    logic       ill;
  } ctrl_t;

  typedef enum logic {RUN, DIV_BUSY} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  ctrl_t         dec, ctrl_n, ctrl_q;
  logic [4:0]    f;
  logic          bad;
  logic          rs2_used;
  logic          hazard;
  logic          is_div;

  assign f = func[4:0];

  always_comb begin
    dec      = '0;
    bad      = 1'b0;
    rs2_used = 1'b0;
    unique case (1'b1)
      (instruction_type == 2'b00): begin
        dec.alusrc = 1'b1;
        dec.imm    = 2'b01;
        if (f[4]) begin
          dec.mw   = 1'b1;
          rs2_used = 1'b1;
        end else begin
          dec.mr  = 1'b1;
          dec.m2r = 1'b1;
          dec.rw  = 1'b1;
        end
      end
      (instruction_type == 2'b01): begin
        dec.rw = 1'b1;
        if (!f[4]) begin
          rs2_used  = 1'b1;
          dec.aluop = {1'b0, f[1:0]};
          bad       = (f[3:2] != 2'b00);
        end else begin
          dec.alusrc = 1'b1;
          dec.imm    = 2'b10;
          dec.aluop  = {1'b0, f[1:0]};
          bad        = (f[3:2] != 2'b01);
        end
      end
      (instruction_type == 2'b10): begin
        dec.aluop = 3'b001;
        dec.rsrc1 = 1'b1;
        dec.rsrc2 = 1'b1;
        rs2_used  = f[4];
        unique case (f[4:3])
          2'b00:   dec.bb  = 1'b1;
          2'b10:   dec.bi  = 1'b1;
          2'b11:   dec.bni = 1'b1;
          default: bad     = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    // Undecodable: a valid slot carrying no side effects.
    if (bad) begin
      dec     = '0;
      dec.ill = 1'b1;
    end
    dec.valid = 1'b1;
  end

  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((ex_rd == rs1) || ((ex_rd == rs2) && rs2_used));
  assign is_div = !dec.ill && (dec.aluop == 3'b011);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ctrl_n   = '0;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      RUN: begin
        in_ready = !hazard || branch_taken;
        if (in_valid && !branch_taken && !hazard) begin
          ctrl_n = dec;
          if (is_div && (DIV_CYCLES > 1)) begin
            state_n = DIV_BUSY;
            cnt_n   = CW'(DIV_CYCLES - 1);
          end
        end
      end
      DIV_BUSY: begin
        busy = 1'b1;
        if (cnt <= CW'(1)) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      cnt    <= '0;
      ctrl_q <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ctrl_q <= ctrl_n;
    end
  end

  assign out_valid = ctrl_q.valid;
  assign BranchB   = ctrl_q.bb;
  assign BranchI   = ctrl_q.bi;
  assign BranchNI  = ctrl_q.bni;
  assign MemToReg  = ctrl_q.m2r;
  assign MemRead   = ctrl_q.mr;
  assign MemWrite  = ctrl_q.mw;
  assign ALUSrc    = ctrl_q.alusrc;
  assign RegWrite  = ctrl_q.rw;
  assign RegSrc2   = ctrl_q.rsrc2;
  assign RegSrc1   = ctrl_q.rsrc1;
  assign ALUOp     = ctrl_q.aluop;
  assign ImmSrc    = ctrl_q.imm;
  assign illegal   = ctrl_q.ill;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed vector bench for pipe_control_unit: decode table plus
// divide-occupancy and reset-abort sequences.
module tb_pipe_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] instruction_type;
  logic [4:0] func;
  logic [3:0] rs1, rs2, ex_rd;
  logic       ex_mem_read, branch_taken;
  logic       in_ready, out_valid, busy, illegal;
  logic       BranchB, BranchI, BranchNI, MemToReg, MemRead, MemWrite;
  logic       ALUSrc, RegWrite, RegSrc2, RegSrc1;
  logic [2:0] ALUOp;
  logic [1:0] ImmSrc;

  int nchk = 0;
  int nfail = 0;

  pipe_control_unit #(.FUNC_W(5), .REG_W(4), .DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .instruction_type(instruction_type), .func(func),
    .rs1(rs1), .rs2(rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .in_ready(in_ready),
    .out_valid(out_valid), .BranchB(BranchB), .BranchI(BranchI),
    .BranchNI(BranchNI), .MemToReg(MemToReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .RegSrc2(RegSrc2), .RegSrc1(RegSrc1), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // valid bb bi bni m2r mr mw alusrc rw rsrc2 rsrc1 | aluop | imm | ill
  function automatic logic [16:0] obs();
    return {out_valid, BranchB, BranchI, BranchNI, MemToReg, MemRead,
            MemWrite, ALUSrc, RegWrite, RegSrc2, RegSrc1, ALUOp,
            ImmSrc, illegal};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [1:0]  t;
    logic [4:0]  f;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic        mr;
    logic [3:0]  rd;
    logic        bt;
    logic        rdy;
    logic [16:0] exp;
    string       nm;
  } vec_t;

  vec_t v[$];

  task automatic drive(input logic iv, input logic [1:0] t,
                       input logic [4:0] f, input logic [3:0] r1,
                       input logic [3:0] r2, input logic mr,
                       input logic [3:0] rd, input logic bt);
    in_valid = iv; instruction_type = t; func = f;
    rs1 = r1; rs2 = r2; ex_mem_read = mr; ex_rd = rd;
    branch_taken = bt;
  endtask

  localparam logic [16:0] BUB = 17'h0;
  localparam logic [16:0] ILL = {11'b10000000000, 3'b000, 2'b00, 1'b1};
  localparam logic [16:0] ADD = {11'b10000000100, 3'b000, 2'b00, 1'b0};
  localparam logic [16:0] ADDI = {11'b10000001100, 3'b000, 2'b10, 1'b0};
  localparam logic [16:0] LD = {11'b10001101100, 3'b000, 2'b01, 1'b0};
  localparam logic [16:0] DIVI = {11'b10000001100, 3'b011, 2'b10, 1'b0};
  localparam logic [16:0] DIVR = {11'b10000000100, 3'b011, 2'b00, 1'b0};

  initial begin
    v.push_back('{1, 2'b01, 5'b00000, 1, 2, 0, 0, 0, 1, ADD, "add"});
    v.push_back('{1, 2'b01, 5'b00001, 1, 2, 0, 0, 0, 1,
      {11'b10000000100, 3'b001, 2'b00, 1'b0}, "sub"});
    v.push_back('{1, 2'b01, 5'b00010, 1, 2, 0, 0, 0, 1,
      {11'b10000000100, 3'b010, 2'b00, 1'b0}, "op2"});
    v.push_back('{1, 2'b01, 5'b10100, 1, 2, 0, 0, 0, 1, ADDI, "addi"});
    v.push_back('{1, 2'b01, 5'b10110, 1, 2, 0, 0, 0, 1,
      {11'b10000001100, 3'b010, 2'b10, 1'b0}, "op2i"});
    v.push_back('{1, 2'b01, 5'b00100, 1, 2, 0, 0, 0, 1, ILL, "data_ill0"});
    v.push_back('{1, 2'b01, 5'b11000, 1, 2, 0, 0, 0, 1, ILL, "data_ill1"});
    v.push_back('{1, 2'b00, 5'b00000, 1, 2, 0, 0, 0, 1, LD, "load"});
    v.push_back('{1, 2'b00, 5'b10000, 1, 2, 0, 0, 0, 1,
      {11'b10000011000, 3'b000, 2'b01, 1'b0}, "store"});
    v.push_back('{1, 2'b10, 5'b00000, 1, 2, 0, 0, 0, 1,
      {11'b11000000011, 3'b001, 2'b00, 1'b0}, "branchb"});
    v.push_back('{1, 2'b10, 5'b10000, 1, 2, 0, 0, 0, 1,
      {11'b10100000011, 3'b001, 2'b00, 1'b0}, "branchi"});
    v.push_back('{1, 2'b10, 5'b11000, 1, 2, 0, 0, 0, 1,
      {11'b10010000011, 3'b001, 2'b00, 1'b0}, "branchni"});
    v.push_back('{1, 2'b10, 5'b01000, 1, 2, 0, 0, 0, 1, ILL, "ctrl_ill"});
    v.push_back('{1, 2'b11, 5'b00000, 1, 2, 0, 0, 0, 1, ILL, "type_ill"});
    v.push_back('{0, 2'b01, 5'b00000, 1, 2, 0, 0, 0, 1, BUB, "no_valid"});
    v.push_back('{1, 2'b00, 5'b00000, 3, 2, 1, 3, 0, 0, BUB, "lu_stall"});
    v.push_back('{1, 2'b00, 5'b00000, 3, 2, 0, 3, 0, 1, LD, "lu_release"});
    v.push_back('{1, 2'b01, 5'b10100, 1, 5, 1, 5, 0, 1, ADDI, "rs2_unused"});
    v.push_back('{1, 2'b01, 5'b00000, 1, 5, 1, 5, 0, 0, BUB, "rs2_hazard"});
    v.push_back('{1, 2'b01, 5'b00000, 0, 2, 1, 0, 0, 1, ADD, "rd_zero"});
    v.push_back('{1, 2'b10, 5'b10000, 1, 2, 0, 0, 1, 1, BUB, "flush_bi"});
    v.push_back('{1, 2'b01, 5'b00000, 3, 2, 1, 3, 1, 1, BUB, "flush_haz"});
    v.push_back('{1, 2'b00, 5'b10000, 1, 7, 1, 7, 0, 0, BUB, "st_rs2_haz"});
    v.push_back('{1, 2'b00, 5'b00000, 1, 7, 1, 7, 0, 1, LD, "ld_rs2_free"});

    rst = 1'b1;
    drive(0, 2'b00, 5'b0, 1, 2, 0, 0, 0);
    #2;
    chk("reset_out", 32'(obs()), 32'(BUB));
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("reset_ready", 32'(in_ready), 32'd1);

    foreach (v[i]) begin
      @(negedge clk);
      drive(v[i].iv, v[i].t, v[i].f, v[i].r1, v[i].r2, v[i].mr, v[i].rd,
            v[i].bt);
      #1 chk({v[i].nm, "_rdy"}, 32'(in_ready), 32'(v[i].rdy));
      @(posedge clk);
      #1 chk(v[i].nm, 32'(obs()), 32'(v[i].exp));
      chk({v[i].nm, "_busy"}, 32'(busy), 32'd0);
    end

    // divi occupies EX: one valid slot, 3 busy cycles, branch ignored.
    @(negedge clk);
    drive(1, 2'b01, 5'b10111, 1, 2, 0, 0, 0);
    #1 chk("div_rdy0", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1, 2'b01, 5'b00000, 1, 2, 0, 0, 1);
    chk("div_issue", 32'(obs()), 32'(DIVI));
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("div_busy%0d", k), 32'(busy), 32'(k <= 3));
      chk($sformatf("div_rdy%0d", k), 32'(in_ready), 32'(k > 3));
      if (k > 1) chk($sformatf("div_bub%0d", k), 32'(obs()), 32'(BUB));
    end
    drive(1, 2'b01, 5'b00000, 1, 2, 0, 0, 0);
    @(posedge clk);
    #1 chk("div_after", 32'(obs()), 32'(ADD));

    // Reset during the second busy cycle aborts the divide.
    @(negedge clk);
    drive(1, 2'b01, 5'b00011, 1, 2, 0, 0, 0);
    @(posedge clk);
    #1 chk("divr_issue", 32'(obs()), 32'(DIVR));
    chk("divr_busy1", 32'(busy), 32'd1);
    drive(0, 2'b00, 5'b0, 1, 2, 0, 0, 0);
    @(posedge clk);
    #2 chk("divr_busy2", 32'(busy), 32'd1);
    rst = 1'b1;
    #1 chk("rst_mid_out", 32'(obs()), 32'(BUB));
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_rel_rdy", 32'(in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 chk($sformatf("rst_no_busy%0d", k), 32'(busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
